// File: rtl/vmem_copy_engine.sv
// Word-copy initiator: reads len words from src, buffers them in an in-order FIFO, writes them to dst.
// Reads are issued only while outstanding + buffered < FIFO_DEPTH; response at edge R gives write valid at R+1.

module vmem_copy_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head_dat = mem[rd_idx];

endmodule

module vmem_copy_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_src,
  input  logic [11:0] cmd_dst,
  input  logic [12:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] rq_addr,
  output logic        rq_we,
  output logic        rq_valid,
  input  logic        rq_ready,
  input  logic [11:0] rs_addr,
  input  logic [31:0] rs_data,
  input  logic        rs_valid,
  output logic        rs_ready,
  output logic [11:0] wq_addr,
  output logic [31:0] wq_data,
  output logic        wq_we,
  output logic        wq_valid,
  input  logic        wq_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [11:0]   rd_ptr, wr_ptr, exp_addr;
  logic [12:0]   rd_left, wr_left;
  logic [CW-1:0] outstanding, fifo_count;
  logic [CW:0]   credit_used;
  logic          accept, rq_fire, wq_fire, rs_take, rs_stray, rs_mismatch;

  assign accept      = (state == S_IDLE) && cmd_valid;
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign rq_valid    = (state == S_RUN) && (rd_left != 13'd0) && (credit_used < DEPTH_V);
  assign rq_fire     = rq_valid && rq_ready;
  assign wq_valid    = (fifo_count != '0);
  assign wq_fire     = wq_valid && wq_ready;

  // A response with nothing outstanding is dropped; a misaddressed one is still buffered.
  assign rs_take     = rs_valid && (outstanding != '0);
  assign rs_stray    = rs_valid && (outstanding == '0);
  assign rs_mismatch = rs_take && (rs_addr != exp_addr);

  vmem_copy_fifo #(.W(32), .DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rs_take),
    .push_dat (rs_data),
    .pop      (wq_fire),
    .head_dat (wq_data),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nx = (cmd_len == 13'd0) ? S_DONE : S_RUN;
      S_RUN:  if (wq_fire && (wr_left == 13'd1)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      exp_addr    <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (accept) begin
        rd_ptr   <= cmd_src;
        wr_ptr   <= cmd_dst;
        exp_addr <= cmd_src;
        rd_left  <= cmd_len;
        wr_left  <= cmd_len;
      end else begin
        if (rq_fire) begin
          rd_ptr  <= rd_ptr + 12'd1;
          rd_left <= rd_left - 13'd1;
        end
        if (wq_fire) begin
          wr_ptr  <= wr_ptr + 12'd1;
          wr_left <= wr_left - 13'd1;
        end
        if (rs_take) exp_addr <= exp_addr + 12'd1;
      end

      case ({rq_fire, rs_take})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (rs_stray || rs_mismatch) err <= 1'b1;
      else if (accept)             err <= 1'b0;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign rq_addr   = rd_ptr;
  assign rq_we     = 1'b0;
  assign rs_ready  = 1'b1;
  assign wq_addr   = wr_ptr;
  assign wq_we     = wq_valid;

endmodule
